// File: rtl/wm_pkg.sv
// Shared constants, FSM state type and pixel saturation helper for the watermark remover.
package wm_pkg;

   localparam int PIX_W     = 8;
   localparam int WGT_W     = 7;
   localparam int NUM_W     = 16;
   localparam int PCT_SCALE = 100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PREP = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Clip a full-width quotient to the largest representable pixel.
   function automatic logic [PIX_W-1:0] sat_pix(input logic [NUM_W-1:0] q);
      if (|q[NUM_W-1:PIX_W]) begin
         return {PIX_W{1'b1}};
      end else begin
         return q[PIX_W-1:0];
      end
   endfunction

endpackage

// File: rtl/watermark_remover_if.sv
// Pixel/weight input and recovered-pixel output handshake bundle.
interface watermark_remover_if;
   import wm_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [PIX_W-1:0] Y_k;
   logic [PIX_W-1:0] W_k;
   logic [WGT_W-1:0] A_k;
   logic [WGT_W-1:0] B_k;
   logic             out_valid;
   logic             out_ready;
   logic [PIX_W-1:0] I_k;
   logic             err;

   modport slave (
      input  in_valid, Y_k, W_k, A_k, B_k, out_ready,
      output in_ready, out_valid, I_k, err
   );

   modport master (
      output in_valid, Y_k, W_k, A_k, B_k, out_ready,
      input  in_ready, out_valid, I_k, err
   );

endinterface

// File: rtl/watermark_remover_seq_div.sv
// Restoring divider, one quotient bit per cycle, MSB first; quo_o/done_o expose the final
// quotient in the same cycle its last bit is resolved so the caller can latch it on that edge.
module seq_div
   import wm_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [NUM_W-1:0] num_i,
   input  logic [WGT_W-1:0] den_i,
   output logic [NUM_W-1:0] quo_o,
   output logic             done_o
);

   localparam int CNT_W = $clog2(NUM_W);

   logic [NUM_W-1:0] num_q, num_d;
   logic [NUM_W-1:0] quo_q, quo_d;
   logic [WGT_W-1:0] rem_q, rem_d;
   logic [WGT_W-1:0] den_q, den_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [WGT_W+1:0] trial_s;
   logic             qbit_s;

   // Sign bit of the widened trial subtraction doubles as the restore flag.
   assign trial_s = {1'b0, rem_q, num_q[NUM_W-1]} - {2'b00, den_q};
   assign qbit_s  = ~trial_s[WGT_W+1];
   assign quo_o   = {quo_q[NUM_W-2:0], qbit_s};
   assign done_o  = busy_q && (cnt_q == {CNT_W{1'b0}});

   // Load on start, otherwise perform one shift/subtract step per busy cycle.
   always_comb begin
      num_d  = num_q;
      quo_d  = quo_q;
      rem_d  = rem_q;
      den_d  = den_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start_i) begin
         num_d  = num_i;
         quo_d  = {NUM_W{1'b0}};
         rem_d  = {WGT_W{1'b0}};
         den_d  = den_i;
         cnt_d  = CNT_W'(NUM_W - 1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         num_d = {num_q[NUM_W-2:0], 1'b0};
         quo_d = {quo_q[NUM_W-2:0], qbit_s};
         if (qbit_s) begin
            rem_d = trial_s[WGT_W-1:0];
         end else begin
            rem_d = {rem_q[WGT_W-2:0], num_q[NUM_W-1]};
         end
         if (cnt_q == {CNT_W{1'b0}}) begin
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         busy_d = 1'b0;
      end
   end

   // Divider state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         num_q  <= {NUM_W{1'b0}};
         quo_q  <= {NUM_W{1'b0}};
         rem_q  <= {WGT_W{1'b0}};
         den_q  <= {WGT_W{1'b0}};
         cnt_q  <= {CNT_W{1'b0}};
         busy_q <= 1'b0;
      end else begin
         num_q  <= num_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         den_q  <= den_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/watermark_remover.sv
// Recovers I = (100*Y - B*W)/A from a watermarked pixel, one pixel in flight at a time.
// Build option WM_UNMARK_ROUND_EN: round the quotient to nearest instead of truncating.
module watermark_remover
   import wm_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   watermark_remover_if.slave bus
);

   state_e           state_q, state_d;
   logic [PIX_W-1:0] y_q, y_d, w_q, w_d;
   logic [WGT_W-1:0] a_q, a_d, b_q, b_d;
   logic [PIX_W-1:0] res_q, res_d;
   logic             err_q, err_d;
   logic             ovld_q, irdy_q;
   logic [NUM_W-1:0] y_scaled_s, bw_s, clamp_s, num_s;
   logic             div_start_s, div_done_s;
   logic [NUM_W-1:0] div_quo_s;

   assign y_scaled_s = NUM_W'(PCT_SCALE) * NUM_W'(y_q);
   assign bw_s       = NUM_W'(b_q) * NUM_W'(w_q);
   // Unsigned compare-and-subtract is the clamped form of the signed difference.
   assign clamp_s    = (y_scaled_s > bw_s) ? (y_scaled_s - bw_s) : {NUM_W{1'b0}};
`ifdef WM_UNMARK_ROUND_EN
   assign num_s      = clamp_s + NUM_W'(a_q >> 1);
`else
   assign num_s      = clamp_s;
`endif

   seq_div u_div (
      .clk     (clk),
      .rst     (rst),
      .start_i (div_start_s),
      .num_i   (num_s),
      .den_i   (a_q),
      .quo_o   (div_quo_s),
      .done_o  (div_done_s)
   );

   assign bus.in_ready  = irdy_q;
   assign bus.out_valid = ovld_q;
   assign bus.I_k       = res_q;
   assign bus.err       = err_q;

   // Handshake FSM next-state and result capture.
   always_comb begin
      state_d     = state_q;
      y_d         = y_q;
      w_d         = w_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      err_d       = err_q;
      div_start_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid && irdy_q) begin
               y_d     = bus.Y_k;
               w_d     = bus.W_k;
               a_d     = bus.A_k;
               b_d     = bus.B_k;
               state_d = PREP;
            end else begin
               state_d = IDLE;
            end
         end
         PREP: begin
            if (a_q == {WGT_W{1'b0}}) begin
               err_d   = 1'b1;
               res_d   = {PIX_W{1'b0}};
               state_d = DONE;
            end else begin
               div_start_s = 1'b1;
               state_d     = DIV;
            end
         end
         DIV: begin
            if (div_done_s) begin
               res_d   = sat_pix(div_quo_s);
               err_d   = 1'b0;
               state_d = DONE;
            end else begin
               state_d = DIV;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, operand and registered-output flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         y_q     <= {PIX_W{1'b0}};
         w_q     <= {PIX_W{1'b0}};
         a_q     <= {WGT_W{1'b0}};
         b_q     <= {WGT_W{1'b0}};
         res_q   <= {PIX_W{1'b0}};
         err_q   <= 1'b0;
         ovld_q  <= 1'b0;
         irdy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         w_q     <= w_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         err_q   <= err_d;
         ovld_q  <= (state_d == DONE);
         irdy_q  <= (state_d == IDLE);
      end
   end

endmodule

// File: tb/tb_watermark_remover.sv
// Directed self-checking bench for watermark_remover; expected values are hand-computed.
module tb_watermark_remover;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   n;

   watermark_remover_if bus ();

   watermark_remover dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One input transfer; operands are scrambled afterwards to show they are not re-sampled.
   task automatic send(input logic [7:0] y, input logic [7:0] w, input logic [6:0] a, input logic [6:0] b);
      bus.in_valid = 1'b1;
      bus.Y_k = y;
      bus.W_k = w;
      bus.A_k = a;
      bus.B_k = b;
      tick();
      bus.in_valid = 1'b0;
      bus.Y_k = 8'($urandom);
      bus.W_k = 8'($urandom);
      bus.A_k = 7'($urandom);
      bus.B_k = 7'($urandom);
   endtask

   task automatic wait_out(output int cycles);
      cycles = 0;
      while (!bus.out_valid && cycles < 40) begin
         tick();
         cycles++;
      end
   endtask

   task automatic accept(input string tag);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_ovld_drop"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_irdy_rise"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.Y_k = 8'd0;
      bus.W_k = 8'd0;
      bus.A_k = 7'd0;
      bus.B_k = 7'd0;

      repeat (2) tick();
      chk("rst_irdy", 32'(bus.in_ready), 32'd0);
      chk("rst_ovld", 32'(bus.out_valid), 32'd0);
      chk("rst_ik", 32'(bus.I_k), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_irdy", 32'(bus.in_ready), 32'd1);

      // Nominal: 20000-2000=18000, /80 = 225.
      send(8'd200, 8'd100, 7'd80, 7'd20);
      chk("nom_busy_irdy", 32'(bus.in_ready), 32'd0);
      wait_out(n);
      chk("nom_lat", 32'(n), 32'd17);
      chk("nom_ik", 32'(bus.I_k), 32'd225);
      chk("nom_err", 32'(bus.err), 32'd0);
      accept("nom");

      // Rounding: 200/3 = 66.67.
      send(8'd2, 8'd0, 7'd3, 7'd0);
      wait_out(n);
`ifdef WM_UNMARK_ROUND_EN
      chk("round_ik", 32'(bus.I_k), 32'd67);
`else
      chk("round_ik", 32'(bus.I_k), 32'd66);
`endif
      accept("round");

      // Mixed: 12300-1350=10950, /70 = 156.43 (156 either way).
      send(8'd123, 8'd45, 7'd70, 7'd30);
      wait_out(n);
      chk("mix_ik", 32'(bus.I_k), 32'd156);
      accept("mix");

      // Negative numerator clamps to zero.
      send(8'd10, 8'd200, 7'd50, 7'd50);
      wait_out(n);
      chk("clamp_ik", 32'(bus.I_k), 32'd0);
      chk("clamp_err", 32'(bus.err), 32'd0);
      accept("clamp");

      // Quotient 510 saturates to 255.
      send(8'd255, 8'd0, 7'd50, 7'd0);
      wait_out(n);
      chk("sat_ik", 32'(bus.I_k), 32'd255);
      accept("sat");

      // Zero alpha: error flag, zero result, short path.
      send(8'd100, 8'd0, 7'd0, 7'd0);
      chk("zero_prep_ovld", 32'(bus.out_valid), 32'd0);
      wait_out(n);
      chk("zero_lat_short", 32'(n >= 1 && n <= 2), 32'd1);
      chk("zero_ik", 32'(bus.I_k), 32'd0);
      chk("zero_err", 32'(bus.err), 32'd1);
      accept("zero");

      // Back-pressure, then a new input offered while the result is accepted.
      send(8'd200, 8'd100, 7'd80, 7'd20);
      wait_out(n);
      chk("bp_lat", 32'(n), 32'd17);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_ik", 32'(bus.I_k), 32'd225);
         chk("bp_ovld", 32'(bus.out_valid), 32'd1);
         chk("bp_irdy", 32'(bus.in_ready), 32'd0);
      end
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.Y_k = 8'd123;
      bus.W_k = 8'd45;
      bus.A_k = 7'd70;
      bus.B_k = 7'd30;
      chk("bp_irdy_at_accept", 32'(bus.in_ready), 32'd0);
      tick();
      bus.out_ready = 1'b0;
      chk("bp_irdy_after", 32'(bus.in_ready), 32'd1);
      chk("bp_ovld_after", 32'(bus.out_valid), 32'd0);
      tick();
      bus.in_valid = 1'b0;
      chk("bp_next_taken", 32'(bus.in_ready), 32'd0);
      wait_out(n);
      chk("bp_next_lat", 32'(n), 32'd17);
      chk("bp_next_ik", 32'(bus.I_k), 32'd156);
      accept("bp_next");

      // Reset in the middle of a division.
      send(8'd200, 8'd100, 7'd80, 7'd20);
      repeat (8) tick();
      rst = 1'b1;
      #1;
      chk("mid_rst_ovld", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_irdy", 32'(bus.in_ready), 32'd0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      chk("mid_rel_irdy", 32'(bus.in_ready), 32'd1);
      repeat (15) tick();
      chk("mid_no_result", 32'(bus.out_valid), 32'd0);
      send(8'd200, 8'd100, 7'd80, 7'd20);
      wait_out(n);
      chk("mid_fresh_lat", 32'(n), 32'd17);
      chk("mid_fresh_ik", 32'(bus.I_k), 32'd225);
      chk("mid_fresh_err", 32'(bus.err), 32'd0);
      accept("mid_fresh");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
